// File: rtl/sram_data_port.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit phases on an asynchronous SRAM.
// Optional out-of-range detection (addr_err output) is enabled by defining SRAM_ADDR_CHECK_EN.
module sram_data_port #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
`ifdef SRAM_ADDR_CHECK_EN
  output logic                   sram_ce_n,
  output logic                   addr_err
`else
  output logic                   sram_ce_n
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int         WORD_W = SRAM_ADDR_W - 1;
  localparam logic [3:0] LAST   = 4'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_op_wr;

  logic              w_req;
  logic              w_phase;
  logic              w_last;
  logic [WORD_W-1:0] w_word;

  assign w_req   = mem_r_en | mem_w_en;
  assign w_phase = (r_state == S_LO) || (r_state == S_HI);
  assign w_last  = (r_cnt == LAST);
  // Offset from the window base, in words; wraps modulo the SRAM capacity.
  assign w_word  = WORD_W'((addr - BASE_ADDR) >> 2);

`ifdef SRAM_ADDR_CHECK_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (SRAM_ADDR_W + 1));
  logic r_err;
  logic w_err;
  assign w_err    = (addr < BASE_ADDR) || ({1'b0, addr} >= LIMIT);
  assign addr_err = r_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_op_wr <= 1'b0;
`ifdef SRAM_ADDR_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_word  <= w_word;
            r_wdata <= wdata;
            r_op_wr <= mem_w_en;
            r_cnt   <= 4'd0;
`ifdef SRAM_ADDR_CHECK_EN
            if (w_err) begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
              if (!mem_w_en) r_rdata <= 32'd0;
            end else begin
              r_state <= S_LO;
            end
`else
            r_state <= S_LO;
`endif
          end
        end
        S_LO, S_HI: begin
          if (w_last) begin
            r_cnt <= 4'd0;
            if (!r_op_wr) begin
              if (r_state == S_LO) r_rdata[15:0]  <= sram_dq_in;
              else                 r_rdata[31:16] <= sram_dq_in;
            end
            r_state <= (r_state == S_LO) ? S_HI : S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          // Pipeline advances on this edge; the lingering request is not re-sampled.
          r_state <= S_IDLE;
`ifdef SRAM_ADDR_CHECK_EN
          r_err   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign ready       = (r_state == S_IDLE) ? ~w_req : (r_state == S_DONE);
  assign rdata       = r_rdata;
  assign sram_addr   = {r_word, (r_state == S_HI)};
  assign sram_ce_n   = ~w_phase;
  assign sram_we_n   = ~(w_phase & r_op_wr);
  assign sram_oe_n   = ~(w_phase & ~r_op_wr);
  assign sram_dq_oe  = w_phase & r_op_wr;
  assign sram_dq_out = !(w_phase && r_op_wr) ? 16'h0000 :
                       (r_state == S_HI) ? r_wdata[31:16] : r_wdata[15:0];

endmodule

// File: tb/tb_sram_data_port.sv
// Randomized bench for sram_data_port with a word-level memory model and a behavioural SRAM.
module tb_sram_data_port;
  localparam int WC = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_r_en, mem_w_en;
  logic [31:0]   addr, wdata, rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic          addr_err;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        seed = 1'b1;
  logic [15:0] mem   [0:1023];
  logic [31:0] model [0:511];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  sram_data_port #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
`ifdef SRAM_ADDR_CHECK_EN
    .sram_ce_n(sram_ce_n), .addr_err(addr_err)
`else
    .sram_ce_n(sram_ce_n)
`endif
  );

  function automatic logic [15:0] seed_of(input int i);
    return 16'(i * 40503 + 12345);
  endfunction

  function automatic logic [16:0] word_of(input logic [31:0] a);
    return 17'((a - 32'd1024) / 4);
  endfunction

  // Asynchronous SRAM: write while selected and strobed, read data while output-enabled.
  always @(posedge clk) begin
    if (seed) begin
      for (int i = 0; i < 1024; i++) mem[i] <= seed_of(i);
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mem[sram_addr[9:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

  task automatic test_access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    logic [16:0]   w;
    logic [AW-1:0] ea;
    logic [15:0]   ed;
    w = word_of(a);
    mem_w_en = wr; mem_r_en = rd; addr = a; wdata = d;
    @(negedge clk);
    n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL req_ready a=%h got %b want 0", a, ready); end
    for (int c = 1; c <= 2 * WC; c++) begin
      @(negedge clk);
      ea = {w, (c > WC)};
      ed = (c > WC) ? d[31:16] : d[15:0];
      n_vec++; if (sram_addr !== ea) begin n_err++; $display("FAIL sram_addr cyc%0d got %h want %h", c, sram_addr, ea); end
      n_vec++;
      if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe} !== (wr ? 4'b0011 : 4'b0100)) begin
        n_err++; $display("FAIL strobes cyc%0d wr=%b got %b", c, wr, {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe});
      end
      if (wr) begin
        n_vec++; if (sram_dq_out !== ed) begin n_err++; $display("FAIL dq_out cyc%0d got %h want %h", c, sram_dq_out, ed); end
      end
      n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL busy_ready cyc%0d got %b want 0", c, ready); end
    end
    @(negedge clk);
    if (wr) model[w[8:0]] = d;
    else    exp_rdata = model[w[8:0]];
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL done_ready a=%h got %b want 1", a, ready); end
    n_vec++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
      n_err++; $display("FAIL done_strobes got %b want 1110", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe});
    end
    n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL rdata a=%h got %h want %h", a, rdata, exp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_idle();
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b want 1", ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = 32'd0; wdata = 32'd0;
    exp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_vec++; if (sram_addr !== '0) begin n_err++; $display("FAIL rst_addr got %h want 0", sram_addr); end
    n_vec++; if (sram_dq_out !== 16'd0) begin n_err++; $display("FAIL rst_dq_out got %h want 0", sram_dq_out); end
    n_vec++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
      n_err++; $display("FAIL rst_strobes got %b want 1110", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe});
    end
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ready); end
    seed = 1'b0;
    for (int w = 0; w < 512; w++) model[w] = {seed_of(2 * w + 1), seed_of(2 * w)};
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    test_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    test_idle();
    @(posedge clk); #1;
    test_access(1'b0, 1'b1, 32'd1024, 32'd0);
    n_vec++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL basic_read got %h want deadbeef", rdata); end
    test_idle();
  endtask

  task automatic test_back_to_back();
    test_access(1'b1, 1'b0, 32'd1028, 32'h12345678);
    test_access(1'b0, 1'b1, 32'd1028, 32'd0);
    n_vec++; if (rdata !== 32'h12345678) begin n_err++; $display("FAIL b2b_read got %h want 12345678", rdata); end
    test_idle();
  endtask

  task automatic test_both_enables();
    logic [31:0] prev;
    prev = exp_rdata;
    test_access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A);
    n_vec++; if (rdata !== prev) begin n_err++; $display("FAIL both_rdata got %h want %h", rdata, prev); end
    test_access(1'b0, 1'b1, 32'd1032, 32'd0);
    n_vec++; if (rdata !== 32'hA5A55A5A) begin n_err++; $display("FAIL both_read got %h want a5a55a5a", rdata); end
    test_idle();
  endtask

`ifndef SRAM_ADDR_CHECK_EN
  task automatic test_wrap();
    test_access(1'b1, 1'b0, 32'd1024 + (32'd1 << 19) + 32'd8, 32'hCAFEF00D);
    test_idle();
    test_access(1'b0, 1'b1, 32'd1032, 32'd0);
    n_vec++; if (rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap_read got %h want cafef00d", rdata); end
    test_idle();
  endtask
`else
  task automatic test_addr_err();
    mem_r_en = 1'b1; mem_w_en = 1'b0; addr = 32'd16;
    @(negedge clk);
    n_vec++; if (sram_ce_n !== 1'b1) begin n_err++; $display("FAIL err_ce0 got %b want 1", sram_ce_n); end
    @(negedge clk);
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL err_ready got %b want 1", ready); end
    n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL err_flag got %b want 1", addr_err); end
    n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL err_rdata got %h want 0", rdata); end
    n_vec++; if (sram_ce_n !== 1'b1) begin n_err++; $display("FAIL err_ce1 got %b want 1", sram_ce_n); end
    exp_rdata = 32'd0;
    @(posedge clk); #1;
    test_idle();
    n_vec++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", addr_err); end
  endtask
`endif

  task automatic test_reset_mid_access();
    mem_w_en = 1'b1; mem_r_en = 1'b0; addr = 32'd1024 + 32'd500 * 4; wdata = 32'h0BADF00D;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe} !== 4'b1110) begin
      n_err++; $display("FAIL midrst_strobes got %b want 1110", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe});
    end
    test_idle();
    exp_rdata = 32'd0;
    n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL midrst_rdata got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_access(1'b0, 1'b1, 32'd1028, 32'd0);
    test_idle();
  endtask

  task automatic test_random();
    int unsigned op, w, gap;
    for (int i = 0; i < 40; i++) begin
      op  = $urandom_range(0, 2);
      w   = $urandom_range(0, 255);
      gap = $urandom_range(0, 2);
      test_access(op != 0, op != 1, 32'd1024 + w * 4 + $urandom_range(0, 3), $urandom);
      if (gap > 0) begin
        test_idle();
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    test_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_both_enables();
`ifndef SRAM_ADDR_CHECK_EN
    test_wrap();
`else
    test_addr_err();
`endif
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
